mp_modaddsub: RTL and testbench
===============================

# mp_modaddsub

Parametrised, limb-serial multi-precision adder/subtractor with optional modular reduction. It is the next generation of the 514-bit add/sub unit in the big-number datapath. Operand width and limb width are generics, and a modular add/sub mode lets the Montgomery/exponentiation controllers use it directly for field arithmetic. It uses a start/done handshake and processes one limb per clock.

## Interface
- N, default 514: operand width in bits.
- LIMB, default 64: bits processed per cycle. Legal range is 1..N+1.
- Derived L = ceil((N+1)/LIMB): limbs per pass. L = 9 for the defaults.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request. Sampled only in IDLE.
- op  in  2  operation, sampled with start: 00 add, 01 sub, 10 modular add, 11 modular sub.
- in_a  in  N  operand A, sampled with start.
- in_b  in  N  operand B, sampled with start.
- in_m  in  N  modulus, sampled with start. Used only when op[1]=1.
- result  out  N+1  result.
- done  out  1  one-cycle completion pulse.
- busy  out  1  high while an operation is in progress.
- corr  out  1  modular correction applied. Valid with done.

## Operation
- Operands are zero-extended to L*LIMB bits and latched when start is accepted. Start is ignored otherwise.
- Each cycle one limb is added or subtracted with a registered carry/borrow, least-significant limb first.
- **op=00:** result = (A+B) mod 2^(N+1). result[N] is the carry.
- **op=01:** result = (A−B) mod 2^(N+1), as a two's complement.
  - Example: 0−1 gives all 515 bits set.
- **op=10, pass 1:** S = A+B.
- **op=10, pass 2:** T = S−M over the padded width.
  - No borrow out: result = T, corr=1.
  - Borrow out: result = S, corr=0.
- **op=11, pass 1:** D = A−B.
- **op=11, pass 2:** always runs.
  - Pass-1 borrow: result = D+M truncated to N+1 bits, corr=1.
  - No borrow: result = D, corr=0.
- Modular results are correct only for A,B < M. In that case result[N]=0. Out-of-range inputs give no guarantee beyond determinism.
- For op=00/01, corr=0.
- **States:**
  - IDLE → PASS1 on accepted start.
  - PASS1 → IDLE after limb L−1 if op[1]=0, otherwise → PASS2.
  - PASS2 → IDLE after limb L−1.
- The limb counter runs 0..L−1 and resets to 0 at each pass boundary.
- The carry register clears at the start of each pass. Subtraction seeds the carry with 1 and uses the inverted subtrahend.

## Timing
- **Reset values:** state IDLE, result 0, done 0, busy 0, corr 0, counter 0, carry 0. Applied immediately and asynchronously.
- **Reset mid-operation:** aborts with no done pulse. Outputs return to reset values. The first start after reset release is accepted normally.
- **Start edge:** start=1 in IDLE at edge E0 latches op and operands. busy=1 from E0.
- **Latency:** done rises at edge E_L for op=00/01 and at E_2L for op=10/11. At the defaults that is 9 and 18 cycles.
- **At the done edge:** busy falls, and result and corr are updated. This is the only edge at which they change.
- done is high for exactly one cycle.
- result and corr hold until the next completion, reset, or nothing else.
- start while busy=1 is ignored: no queuing, no corruption.
- start in the cycle where done=1 is accepted, because busy is already 0. This gives back-to-back operations with no idle gap.
- Inputs need only be stable at the accepting edge. Later changes have no effect.

## Test plan
- **Add 1+1:** op=00, A=1, B=1, N=514, LIMB=64 → result=2; done at exactly E9, one cycle wide; busy high E0..E9.
- **Sub:** op=01, 1−1 → 0. Then 0−1 → 2^515−1. Also A=B=2^514−1 with op=00 → 2^515−2, result[514]=1.
- **Modular add:** op=10, M=13.
  - A=7, B=9 → 3, corr=1, done at E18.
  - A=2, B=3 → 5, corr=0.
- **Modular sub:** op=11, M=13.
  - A=3, B=5 → 11, corr=1.
  - A=9, B=4 → 5, corr=0.
- **Handshake:**
  - Second start and changed operands at E3 of an add are ignored: the original result arrives at E9.
  - A start in the done cycle is accepted: the next done comes 9 cycles later.
- **Reset and parameters:**
  - reset pulse at E4 mid-add → no done; result=0; busy=0. The next add 5+6 → 11.
  - Repeat the add and sub vectors with LIMB=515 (L=1) and LIMB=1 (L=515). Latency scales to L / 2L.

Source files
------------

// File: rtl/mp_modaddsub.sv
// mp_modaddsub: limb-serial multi-precision adder/subtractor with optional
// modular reduction. One LIMB-bit slice is processed per clock, least
// significant first. Plain add/sub takes one pass of L limbs. Modular
// add/sub takes a second pass that subtracts or adds the modulus, and then
// selects either the pass-1 or the pass-2 value.
module mp_modaddsub #(
  parameter int N    = 514,
  parameter int LIMB = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] in_m,
  output logic [N:0]   result,
  output logic         done,
  output logic         busy,
  output logic         corr
);

  // Limbs per pass: ceil((N+1)/LIMB), and the padded working width.
  localparam int L  = (N + LIMB) / LIMB;
  localparam int W  = L * LIMB;
  localparam int CW = (L > 1) ? $clog2(L) : 1;
  localparam logic [CW-1:0] LAST = CW'(L - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PASS1 = 2'd1;
  localparam logic [1:0] S_PASS2 = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    r_op;
  logic [W-1:0]  r_a;       // operand A, shifted right one limb per pass-1 cycle
  logic [W-1:0]  r_b;       // operand B, shifted right one limb per pass-1 cycle
  logic [W-1:0]  r_m;       // modulus on the way out, pass-2 result on the way in
  logic [W-1:0]  r_s;       // pass-1 result (S or D); rotated during pass 2
  logic [CW-1:0] r_cnt;
  logic          r_carry;
  logic          r_c1;      // carry out of pass 1 (1 = no borrow for subtraction)
  logic [N:0]    r_result;
  logic          r_done;
  logic          r_corr;

  logic            w_pass2;
  logic            w_sub;
  logic            w_last;
  logic            w_cin;
  logic [LIMB-1:0] w_x;
  logic [LIMB-1:0] w_y;
  logic [LIMB-1:0] w_sum;
  logic            w_cout;
  logic [W-1:0]    w_a_sh;
  logic [W-1:0]    w_b_sh;
  logic [W-1:0]    w_s_ins;   // r_s with the new pass-1 limb shifted in at the top
  logic [W-1:0]    w_s_rot;   // r_s rotated by one limb (restores S after L steps)
  logic [W-1:0]    w_m_ins;   // r_m with the new pass-2 limb shifted in at the top

  // Operand selection for the current limb and pass.
  always_comb begin
    w_pass2 = (r_state == S_PASS2);
    // Pass 2 subtracts M for modular add, adds M for modular sub.
    w_sub   = w_pass2 ? ~r_op[0] : r_op[0];
    w_last  = (r_cnt == LAST);
    w_cin   = (r_cnt == '0) ? w_sub : r_carry;
    w_x     = w_pass2 ? r_s[LIMB-1:0] : r_a[LIMB-1:0];
    w_y     = w_pass2 ? r_m[LIMB-1:0] : r_b[LIMB-1:0];
  end

  // One-limb adder; subtraction uses the inverted subtrahend with carry-in 1.
  always_comb begin
    {w_cout, w_sum} = {1'b0, w_x} + {1'b0, w_y ^ {LIMB{w_sub}}}
                    + {{LIMB{1'b0}}, w_cin};
  end

  generate
    if (L > 1) begin : g_multi
      // Limb shifters: operands move right, results enter at the top.
      always_comb begin
        w_a_sh  = {{LIMB{1'b0}}, r_a[W-1:LIMB]};
        w_b_sh  = {{LIMB{1'b0}}, r_b[W-1:LIMB]};
        w_s_ins = {w_sum, r_s[W-1:LIMB]};
        w_s_rot = {r_s[LIMB-1:0], r_s[W-1:LIMB]};
        w_m_ins = {w_sum, r_m[W-1:LIMB]};
      end
    end else begin : g_single
      // A single limb covers the whole word, so nothing shifts.
      always_comb begin
        w_a_sh  = '0;
        w_b_sh  = '0;
        w_s_ins = w_sum;
        w_s_rot = r_s;
        w_m_ins = w_sum;
      end
    end
  endgenerate

  // Control FSM, limb counter, carry chain and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_m      <= '0;
      r_s      <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_c1     <= 1'b0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_corr   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= op;
            r_a     <= {{(W-N){1'b0}}, in_a};
            r_b     <= {{(W-N){1'b0}}, in_b};
            r_m     <= {{(W-N){1'b0}}, in_m};
            r_s     <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_state <= S_PASS1;
          end
        end
        S_PASS1: begin
          r_a     <= w_a_sh;
          r_b     <= w_b_sh;
          r_s     <= w_s_ins;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_c1    <= w_cout;
            if (r_op[1]) begin
              r_state <= S_PASS2;
            end else begin
              r_state  <= S_IDLE;
              r_done   <= 1'b1;
              r_result <= w_s_ins[N:0];
              r_corr   <= 1'b0;
            end
          end
        end
        S_PASS2: begin
          r_s     <= w_s_rot;
          r_m     <= w_m_ins;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_state <= S_IDLE;
            r_done  <= 1'b1;
            if (r_op[0]) begin
              // Modular sub: add M back only when pass 1 borrowed.
              r_corr   <= ~r_c1;
              r_result <= r_c1 ? w_s_rot[N:0] : w_m_ins[N:0];
            end else begin
              // Modular add: keep S - M only when it did not borrow.
              r_corr   <= w_cout;
              r_result <= w_cout ? w_m_ins[N:0] : w_s_rot[N:0];
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Output drive.
  always_comb begin
    result = r_result;
    done   = r_done;
    busy   = (r_state != S_IDLE);
    corr   = r_corr;
  end

endmodule

// File: tb/tb_mp_modaddsub.sv
// Testbench for mp_modaddsub: three instances (LIMB = 64, 515, 1) share
// operand inputs; each has its own start and outputs.
module tb_mp_modaddsub;

  localparam int N = 514;

  typedef struct {
    logic [1:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] m;
    logic [N:0]   r;
    logic         c;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] m;
  logic         start [3];
  logic [N:0]   res   [3];
  logic         done  [3];
  logic         busy  [3];
  logic         corr  [3];

  int lat [3] = '{9, 1, 515};
  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mp_modaddsub #(.N(N), .LIMB(64)) u0 (
    .clk(clk), .reset(reset), .start(start[0]), .op(op),
    .in_a(a), .in_b(b), .in_m(m),
    .result(res[0]), .done(done[0]), .busy(busy[0]), .corr(corr[0]));

  mp_modaddsub #(.N(N), .LIMB(515)) u1 (
    .clk(clk), .reset(reset), .start(start[1]), .op(op),
    .in_a(a), .in_b(b), .in_m(m),
    .result(res[1]), .done(done[1]), .busy(busy[1]), .corr(corr[1]));

  mp_modaddsub #(.N(N), .LIMB(1)) u2 (
    .clk(clk), .reset(reset), .start(start[2]), .op(op),
    .in_a(a), .in_b(b), .in_m(m),
    .result(res[2]), .done(done[2]), .busy(busy[2]), .corr(corr[2]));

  function automatic logic [N-1:0] nv(input logic [31:0] x);
    return {{(N-32){1'b0}}, x};
  endfunction

  function automatic logic [N:0] rv(input logic [31:0] x);
    return {{(N-31){1'b0}}, x};
  endfunction

  function automatic logic [N-1:0] rnd_n();
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < 17; i++) v = {v[N-33:0], 32'($urandom())};
    return v;
  endfunction

  // Reference: the arithmetic definition of each operation.
  function automatic void model(input logic [1:0] o, input logic [N-1:0] x,
                                input logic [N-1:0] y, input logic [N-1:0] mm,
                                output logic [N:0] r, output logic c);
    logic [N:0] xx, yy, mx, s;
    xx = {1'b0, x};
    yy = {1'b0, y};
    mx = {1'b0, mm};
    c  = 1'b0;
    case (o)
      2'b00: r = xx + yy;
      2'b01: r = xx - yy;
      2'b10: begin
        s = xx + yy;
        if (s >= mx) begin r = s - mx; c = 1'b1; end
        else r = s;
      end
      default: begin
        if (xx >= yy) r = xx - yy;
        else begin r = xx - yy + mx; c = 1'b1; end
      end
    endcase
  endfunction

  task automatic check_vec(input string nm, input logic [N:0] act, input logic [N:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic check_bit(input string nm, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", nm, act, exp);
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Present a request; returns at the negedge after the accepting edge E0.
  task automatic start_op(input int k, input logic [1:0] o, input logic [N-1:0] x,
                          input logic [N-1:0] y, input logic [N-1:0] mm);
    @(negedge clk);
    op = o; a = x; b = y; m = mm;
    start[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[k] = 1'b0;
    check_bit($sformatf("busy_at_E0_u%0d", k), busy[k], 1'b1);
  endtask

  // Counts edges after E0 until done is seen; n = -1 on timeout.
  task automatic wait_done(input int k, input int n0, output int n);
    bit got;
    bit bz;
    got = 0;
    bz  = 1;
    n   = n0;
    while (!got && n < 2 * lat[k] + 8) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done[k]) got = 1;
      else if (!busy[k]) bz = 0;
    end
    if (!got) n = -1;
    check_bit($sformatf("busy_until_done_u%0d", k), bz, 1'b1);
    check_bit($sformatf("busy_low_at_done_u%0d", k), busy[k], 1'b0);
  endtask

  task automatic run_vec(input int k, input logic [1:0] o, input logic [N-1:0] x,
                         input logic [N-1:0] y, input logic [N-1:0] mm,
                         input logic [N:0] er, input logic ec, input string nm);
    int n;
    int exp_lat;
    exp_lat = o[1] ? 2 * lat[k] : lat[k];
    start_op(k, o, x, y, mm);
    wait_done(k, 0, n);
    check_int({nm, "_latency"}, n, exp_lat);
    check_vec({nm, "_result"}, res[k], er);
    check_bit({nm, "_corr"}, corr[k], ec);
    @(posedge clk);
    @(negedge clk);
    check_bit({nm, "_done_one_cycle"}, done[k], 1'b0);
    check_vec({nm, "_result_hold"}, res[k], er);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         tbl [8];
    logic [N-1:0] ones_n;
    logic [N:0]   ones_r;
    logic [N:0]   big;
    logic [N-1:0] x, y, mm;
    logic [N:0]   er;
    logic         ec;
    logic [1:0]   o;
    int           n;
    int           k;
    bit           got;

    ones_n = '1;
    ones_r = '1;
    big    = ones_r;
    big[0] = 1'b0;

    tbl[0] = '{op: 2'b00, a: nv(1), b: nv(1), m: nv(0), r: rv(2), c: 1'b0};
    tbl[1] = '{op: 2'b01, a: nv(1), b: nv(1), m: nv(0), r: rv(0), c: 1'b0};
    tbl[2] = '{op: 2'b01, a: nv(0), b: nv(1), m: nv(0), r: ones_r, c: 1'b0};
    tbl[3] = '{op: 2'b00, a: ones_n, b: ones_n, m: nv(0), r: big, c: 1'b0};
    tbl[4] = '{op: 2'b10, a: nv(7), b: nv(9), m: nv(13), r: rv(3), c: 1'b1};
    tbl[5] = '{op: 2'b10, a: nv(2), b: nv(3), m: nv(13), r: rv(5), c: 1'b0};
    tbl[6] = '{op: 2'b11, a: nv(3), b: nv(5), m: nv(13), r: rv(11), c: 1'b1};
    tbl[7] = '{op: 2'b11, a: nv(9), b: nv(4), m: nv(13), r: rv(5), c: 1'b0};

    for (int i = 0; i < 3; i++) start[i] = 1'b0;
    op = 2'b00; a = '0; b = '0; m = '0;

    // Reset state.
    reset = 1'b1;
    #12;
    for (int i = 0; i < 3; i++) begin
      check_vec($sformatf("reset_result_u%0d", i), res[i], '0);
      check_bit($sformatf("reset_done_u%0d", i), done[i], 1'b0);
      check_bit($sformatf("reset_busy_u%0d", i), busy[i], 1'b0);
      check_bit($sformatf("reset_corr_u%0d", i), corr[i], 1'b0);
    end
    @(negedge clk);
    reset = 1'b0;

    // Directed vectors on every limb width.
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 8; j++)
        run_vec(i, tbl[j].op, tbl[j].a, tbl[j].b, tbl[j].m, tbl[j].r, tbl[j].c,
                $sformatf("vec%0d_u%0d", j, i));

    // Random operations against the reference model.
    for (int i = 0; i < 24; i++) begin
      k  = i % 3;
      o  = 2'($urandom_range(0, 3));
      mm = rnd_n();
      x  = rnd_n();
      y  = rnd_n();
      if ($urandom_range(0, 1) == 1) begin
        mm[0] = 1'b1;
        x = x % mm;
        y = y % mm;
      end
      model(o, x, y, mm, er, ec);
      run_vec(k, o, x, y, mm, er, ec, $sformatf("rnd%0d_u%0d_op%0d", i, k, o));
    end

    // Start and operand changes while busy are ignored.
    start_op(0, 2'b00, nv(1), nv(1), nv(0));
    n = 0;
    repeat (2) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    op = 2'b01; a = nv(100); b = nv(50); start[0] = 1'b1;
    @(posedge clk);
    n++;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0, n, n);
    check_int("ignored_start_latency", n, 9);
    check_vec("ignored_start_result", res[0], rv(2));

    // Start in the done cycle is accepted with no gap.
    start_op(0, 2'b00, nv(2), nv(3), nv(0));
    wait_done(0, 0, n);
    check_int("b2b_first_latency", n, 9);
    check_vec("b2b_first_result", res[0], rv(5));
    op = 2'b00; a = nv(4); b = nv(5); start[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    check_bit("b2b_second_accepted", busy[0], 1'b1);
    wait_done(0, 0, n);
    check_int("b2b_second_latency", n, 9);
    check_vec("b2b_second_result", res[0], rv(9));

    // Reset in the middle of an add aborts it.
    start_op(0, 2'b00, nv(1), nv(1), nv(0));
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    check_vec("midreset_result", res[0], '0);
    check_bit("midreset_busy", busy[0], 1'b0);
    check_bit("midreset_done", done[0], 1'b0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    got = 0;
    repeat (22) begin
      @(posedge clk);
      @(negedge clk);
      if (done[0]) got = 1;
    end
    check_bit("midreset_no_done", got, 1'b0);
    check_bit("midreset_idle", busy[0], 1'b0);
    run_vec(0, 2'b00, nv(5), nv(6), nv(0), rv(11), 1'b0, "after_reset_add");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
